// File: rtl/sram_req_ctrl.sv
//==============================================================================
// Module   : sram_req_ctrl
// Brief    : Single-word request controller for the 1024x32 SRAM core port.
//            Optional statistics outputs are enabled by SRAM_REQ_CTRL_STATS_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module sram_req_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        n_rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [9:0]  req_addr,
    input  logic [31:0] req_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,

    output logic [9:0]  sram_addr,
    output logic        sram_read_en,
    output logic        sram_write_en,
    output logic [31:0] sram_write_data,
    input  logic [31:0] sram_read_data,
    input  logic [1:0]  sram_state
`ifdef SRAM_REQ_CTRL_STATS_EN
    ,
    output logic [15:0] stat_ok_count,
    output logic [15:0] stat_err_count
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARB  = 2'd1;
    localparam logic [1:0] ST_ACC  = 2'd2;
    localparam logic [1:0] ST_RSP  = 2'd3;

    localparam logic [1:0] SRAM_FREE   = 2'd0;
    localparam logic [1:0] SRAM_ACCESS = 2'd2;
    localparam logic [1:0] SRAM_ERROR  = 2'd3;

    logic [1:0]    state_q,     state_d;
    logic          op_q,        op_d;
    logic [9:0]    addr_q,      addr_d;
    logic [31:0]   wdata_q,     wdata_d;
    logic          rd_en_q,     rd_en_d;
    logic          wr_en_q,     wr_en_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rdata_q,     rdata_d;
    logic          err_q,       err_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic          finish;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_en_d     = rd_en_q;
        wr_en_d     = wr_en_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        timer_d     = timer_q;
        finish      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = ST_ARB;
                end
            end

            ST_ARB: begin
                if (sram_state == SRAM_FREE) begin
                    rd_en_d = ~op_q;
                    wr_en_d = op_q;
                    timer_d = '0;
                    state_d = ST_ACC;
                end
            end

            ST_ACC: begin
                timer_d = timer_q + TW'(1);
                // ACCESS outranks ERROR, which outranks the timeout.
                if (sram_state == SRAM_ACCESS) begin
                    finish  = 1'b1;
                    rdata_d = op_q ? 32'd0 : sram_read_data;
                    err_d   = 1'b0;
                end else if (sram_state == SRAM_ERROR) begin
                    finish  = 1'b1;
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    finish  = 1'b1;
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                end
                if (finish) begin
                    rd_en_d     = 1'b0;
                    wr_en_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    timer_d     = '0;
                    state_d     = ST_RSP;
                end
            end

            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            timer_q     <= timer_d;
        end
    end

    assign req_ready       = (state_q == ST_IDLE);
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rdata_q;
    assign rsp_error       = err_q;
    assign sram_addr       = addr_q;
    assign sram_read_en    = rd_en_q;
    assign sram_write_en   = wr_en_q;
    assign sram_write_data = wdata_q;

`ifdef SRAM_REQ_CTRL_STATS_EN
    logic [15:0] ok_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ok_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (finish) begin
            if (!err_d && ok_cnt_q != 16'hFFFF) begin
                ok_cnt_q <= ok_cnt_q + 16'd1;
            end
            if (err_d && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign stat_ok_count  = ok_cnt_q;
    assign stat_err_count = err_cnt_q;
`endif

    a_one_hot_enable: assert property (@(posedge clk) disable iff (!n_rst)
        !(rd_en_q && wr_en_q));

endmodule

`default_nettype wire

// File: tb/tb_sram_req_ctrl.sv
//==============================================================================
// Module   : tb_sram_req_ctrl
// Brief    : Directed bench for sram_req_ctrl with a transaction-level model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_sram_req_ctrl;

    localparam int TO = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0, sram_read_data = '0;
    logic [1:0]  sram_state = FREE;
    logic        req_ready, rsp_valid, rsp_error, sram_read_en, sram_write_en;
    logic [31:0] rsp_rdata, sram_write_data;
    logic [9:0]  sram_addr;
`ifdef SRAM_REQ_CTRL_STATS_EN
    logic [15:0] stat_ok, stat_err;
`endif

    int total = 0;
    int bad   = 0;

    sram_req_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .sram_addr(sram_addr), .sram_read_en(sram_read_en),
        .sram_write_en(sram_write_en), .sram_write_data(sram_write_data),
        .sram_read_data(sram_read_data), .sram_state(sram_state)
`ifdef SRAM_REQ_CTRL_STATS_EN
        , .stat_ok_count(stat_ok), .stat_err_count(stat_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: a request is outstanding until the SRAM grants it,
    // then it ages in the access phase until a terminal status or the age limit.
    logic        m_pending, m_granted, m_wr, m_rv, m_err;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    int          m_age, m_ok_n, m_err_n;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_pending <= 0; m_granted <= 0; m_wr <= 0; m_rv <= 0; m_err <= 0;
            m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_age <= 0;
            m_ok_n <= 0; m_err_n <= 0;
        end else begin
            if (!m_pending && !m_rv) begin
                if (req_valid) begin
                    m_pending <= 1; m_wr <= req_write;
                    m_addr <= req_addr; m_wdata <= req_wdata;
                end
            end else if (m_pending && !m_granted) begin
                if (sram_state == FREE) begin
                    m_granted <= 1; m_age <= 0;
                end
            end else if (m_granted) begin
                if (sram_state == ACCESS || sram_state == ERROR || m_age == TO - 1) begin
                    m_pending <= 0; m_granted <= 0; m_rv <= 1;
                    m_err   <= (sram_state != ACCESS);
                    m_rdata <= (sram_state == ACCESS && !m_wr) ? sram_read_data : 32'd0;
                    if (sram_state == ACCESS) m_ok_n <= (m_ok_n < 65535) ? m_ok_n + 1 : m_ok_n;
                    else m_err_n <= (m_err_n < 65535) ? m_err_n + 1 : m_err_n;
                end else begin
                    m_age <= m_age + 1;
                end
            end
            if (m_rv && rsp_ready) m_rv <= 0;
        end
    end

    always @(negedge clk) begin
        if (n_rst) begin
            chk("req_ready", 32'(req_ready), 32'(!m_pending && !m_rv));
            chk("rd_en", 32'(sram_read_en), 32'(m_granted && !m_wr));
            chk("wr_en", 32'(sram_write_en), 32'(m_granted && m_wr));
            chk("sram_addr", 32'(sram_addr), 32'(m_addr));
            chk("sram_wdata", sram_write_data, m_wdata);
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
            if (m_rv) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_error", 32'(rsp_error), 32'(m_err));
            end
`ifdef SRAM_REQ_CTRL_STATS_EN
            chk("stat_ok", 32'(stat_ok), 32'(m_ok_n));
            chk("stat_err", 32'(stat_err), 32'(m_err_n));
`endif
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One request; cycle 0 is the accept cycle. SRAM script: n_arb non-FREE
    // cycles in arbitration, then FREE, then n_wait BUSY access cycles, then fin.
    task automatic txn(input logic wr, input logic [9:0] a, input logic [31:0] d,
                       input int n_arb, input int n_wait, input logic [1:0] fin,
                       input logic [31:0] rd, input int stall,
                       output int lat, output int nrd, output int nwr,
                       output logic [31:0] rdat, output logic er,
                       output logic [9:0] en_addr, output logic [31:0] en_data);
        logic seen;
        lat = -1; nrd = 0; nwr = 0; rdat = '0; er = 1'b0;
        en_addr = '0; en_data = '0; seen = 1'b0;
        step();
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        sram_state = FREE; sram_read_data = rd; rsp_ready = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            step();
            // Keep a scrambled request asserted: it must be ignored while busy.
            req_write = ~wr; req_addr = ~a; req_wdata = ~d;
            if (sram_read_en) nrd++;
            if (sram_write_en) nwr++;
            if ((sram_read_en || sram_write_en) && !seen) begin
                seen = 1'b1; en_addr = sram_addr; en_data = sram_write_data;
            end
            if (rsp_valid) begin
                lat = cyc;
                break;
            end
            if (cyc <= n_arb)              sram_state = BUSY;
            else if (cyc == n_arb + 1)     sram_state = FREE;
            else if (cyc - n_arb - 2 < n_wait) sram_state = BUSY;
            else                           sram_state = fin;
        end
        req_valid = 1'b0;
        sram_state = FREE;
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL rsp_wait: got no rsp_valid expected one within 200 cycles");
            return;
        end
        rdat = rsp_rdata; er = rsp_error;
        for (int s = 0; s < stall; s++) begin
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rdata", rsp_rdata, rdat);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("hs_req_ready", 32'(req_ready), 32'd1);
        chk("hs_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    int          lat, nrd, nwr;
    logic [31:0] rdat, en_data;
    logic        er;
    logic [9:0]  en_addr;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rd_en", 32'(sram_read_en), 32'd0);
        chk("rst_wr_en", 32'(sram_write_en), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        step();
        n_rst = 1'b1;

        txn(1'b1, 10'h005, 32'hDEADBEEF, 0, 0, ACCESS, 32'h0BAD_0BAD, 0,
            lat, nrd, nwr, rdat, er, en_addr, en_data);
        chk("wr_latency", lat, 3);
        chk("wr_en_cycles", nwr, 1);
        chk("wr_rd_en_cycles", nrd, 0);
        chk("wr_addr", 32'(en_addr), 32'h005);
        chk("wr_data", en_data, 32'hDEADBEEF);
        chk("wr_err", 32'(er), 32'd0);
        chk("wr_rdata", rdat, 32'd0);

        txn(1'b0, 10'h3FF, 32'h0, 0, 3, ACCESS, 32'h12345678, 0,
            lat, nrd, nwr, rdat, er, en_addr, en_data);
        chk("rdbusy_rd_en_cycles", nrd, 4);
        chk("rdbusy_latency", lat, 6);
        chk("rdbusy_addr", 32'(en_addr), 32'h3FF);
        chk("rdbusy_rdata", rdat, 32'h12345678);
        chk("rdbusy_err", 32'(er), 32'd0);

        txn(1'b0, 10'h010, 32'h0, 0, 1, ERROR, 32'hAAAA5555, 0,
            lat, nrd, nwr, rdat, er, en_addr, en_data);
        chk("err_rd_en_cycles", nrd, 2);
        chk("err_latency", lat, 4);
        chk("err_err", 32'(er), 32'd1);
        chk("err_rdata", rdat, 32'd0);
`ifdef SRAM_REQ_CTRL_STATS_EN
        chk("err_stat_err", 32'(stat_err), 32'd1);
        chk("err_stat_ok", 32'(stat_ok), 32'd2);
`endif

        txn(1'b0, 10'h020, 32'h0, 0, 100, BUSY, 32'h5A5A5A5A, 0,
            lat, nrd, nwr, rdat, er, en_addr, en_data);
        chk("to_acc_cycles", nrd, 4);
        chk("to_latency", lat, 6);
        chk("to_err", 32'(er), 32'd1);
        chk("to_rdata", rdat, 32'd0);

        txn(1'b0, 10'h155, 32'h0, 5, 0, ACCESS, 32'hCAFEF00D, 3,
            lat, nrd, nwr, rdat, er, en_addr, en_data);
        chk("bp_rd_en_cycles", nrd, 1);
        chk("bp_latency", lat, 8);
        chk("bp_rdata", rdat, 32'hCAFEF00D);
        chk("bp_err", 32'(er), 32'd0);

        // Reset in the middle of a read access.
        step();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h123; sram_state = FREE;
        step();
        req_valid = 1'b0;
        step();
        chk("mid_rd_en", 32'(sram_read_en), 32'd1);
        sram_state = BUSY;
        #2 n_rst = 1'b0;
        #1;
        chk("mid_rst_rd_en", 32'(sram_read_en), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        step();
        step();
        n_rst = 1'b1;
        sram_state = FREE;

        txn(1'b0, 10'h0AA, 32'h0, 0, 0, ACCESS, 32'h00C0FFEE, 1,
            lat, nrd, nwr, rdat, er, en_addr, en_data);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_rdata", rdat, 32'h00C0FFEE);
        chk("post_rst_err", 32'(er), 32'd0);
`ifdef SRAM_REQ_CTRL_STATS_EN
        chk("post_rst_stat_ok", 32'(stat_ok), 32'd1);
        chk("post_rst_stat_err", 32'(stat_err), 32'd0);
`endif

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
